// File: rtl/branch_pht.sv
// branch_pht: pattern history table of 2-bit saturating counters for the
// two-level branch predictor, plus an in-order queue that remembers the
// table index and prediction of every branch between fetch and execute.
// Prediction is a pure table read; training, misprediction detection and
// wrong-path discard all happen when execute resolves the oldest branch.

module branch_pht #(
  parameter int PC_BITS   = 4,
  parameter int HIST_BITS = 2,
  parameter int QDEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          pcF,
  input  logic                 branchF,
  input  logic                 stallF,
  input  logic [HIST_BITS-1:0] history,
  output logic                 predictTaken,
  input  logic                 resolveE,
  input  logic                 isTakenE,
  output logic                 mispredictE,
  output logic                 queueFull,
  output logic                 queueEmpty,
  output logic                 overflowErr
);

  localparam int IDX     = PC_BITS + HIST_BITS;
  localparam int ENTRIES = 1 << IDX;
  // QDEPTH is a power of two of at least 2, so pointers wrap for free
  localparam int QW      = $clog2(QDEPTH);

  typedef logic [IDX-1:0] idx_t;
  typedef logic [QW-1:0]  ptr_t;
  // one extra bit so a full queue and an empty queue have different counts
  typedef logic [QW:0]    count_t;

  logic [1:0] pht [ENTRIES];
  idx_t       qIdx [QDEPTH];
  logic       qPred [QDEPTH];

  ptr_t   head;
  ptr_t   tail;
  count_t count;
  count_t countNext;
  logic   overflowReg;

  idx_t       idxF;
  idx_t       headIdx;
  logic       headPred;
  logic [1:0] headCnt;
  logic [1:0] trainedCnt;

  logic lookup;
  logic enqueue;
  logic dequeue;
  logic flush;
  logic dropped;

  // PC bits outside the index window never influence the predictor
  logic pcUnused;

  assign idxF     = {pcF[PC_BITS+1:2], history};
  assign pcUnused = ^{pcF[31:PC_BITS+2], pcF[1:0]};

  // lookup is a zero-latency read; a same-cycle update is not bypassed
  assign predictTaken = pht[idxF][1];

  assign queueEmpty  = (count == '0);
  assign queueFull   = (count == count_t'(QDEPTH));
  assign overflowErr = overflowReg;

  assign headIdx  = qIdx[head];
  assign headPred = qPred[head];
  assign headCnt  = pht[headIdx];

  assign lookup      = branchF & ~stallF;
  assign dequeue     = resolveE & ~queueEmpty;
  assign mispredictE = dequeue & (isTakenE != headPred);
  // everything younger than a mispredicted branch is wrong-path
  assign flush       = mispredictE;
  // a full queue still accepts a lookup when the head leaves this cycle
  assign enqueue     = lookup & ~flush & (~queueFull | dequeue);
  assign dropped     = lookup & queueFull & ~dequeue;

  // saturating step of the resolving branch's counter toward its outcome
  always_comb begin
    trainedCnt = headCnt;
    if (isTakenE) begin
      if (headCnt != 2'b11) begin
        trainedCnt = headCnt + 2'b01;
      end
    end else begin
      if (headCnt != 2'b00) begin
        trainedCnt = headCnt - 2'b01;
      end
    end
  end

  // occupancy after this cycle's push/pop, or zero when the queue is flushed
  always_comb begin
    countNext = count;
    if (flush) begin
      countNext = '0;
    end else if (enqueue && !dequeue) begin
      countNext = count + count_t'(1);
    end else if (dequeue && !enqueue) begin
      countNext = count - count_t'(1);
    end
  end

  // counter table: every entry starts weakly not-taken, trained on resolve
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht[i] <= 2'b01;
      end
    end else if (dequeue) begin
      pht[headIdx] <= trainedCnt;
    end
  end

  // queue payload; slots are only read while the count says they are live
  always_ff @(posedge clk) begin
    if (enqueue) begin
      qIdx[tail]  <= idxF;
      qPred[tail] <= predictTaken;
    end
  end

  // queue pointers, occupancy and the sticky dropped-lookup flag
  always_ff @(posedge clk) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      overflowReg <= 1'b0;
    end else begin
      count <= countNext;
      if (flush) begin
        head <= head + ptr_t'(1);
        tail <= head + ptr_t'(1);
      end else begin
        if (dequeue) begin
          head <= head + ptr_t'(1);
        end
        if (enqueue) begin
          tail <= tail + ptr_t'(1);
        end
      end
      if (dropped) begin
        overflowReg <= 1'b1;
      end
    end
  end

endmodule
